// File: rtl/ic74ls161.sv
// SN74LS161A synchronous 4-bit binary counter, pin-accurate 16-pin DIP model.
// Async active-low clear, sync active-low load, count enables ENP/ENT, ripple carry out.
module ic74ls161 #(
  parameter int unsigned TPD_CLK_Q = 0,
  parameter int unsigned TPD_CLR_Q = 0,
  parameter int unsigned TPD_RCO   = 0
) (
  input  logic port1,   // CLR_n
  input  logic port2,   // CLK
  input  logic port3,   // A (LSB)
  input  logic port4,   // B
  input  logic port5,   // C
  input  logic port6,   // D (MSB)
  input  logic port7,   // ENP
  input  logic port8,   // GND
  input  logic port9,   // LOAD_n
  input  logic port10,  // ENT
  output logic port11,  // QD
  output logic port12,  // QC
  output logic port13,  // QB
  output logic port14,  // QA
  output logic port15,  // RCO
  input  logic port16   // VCC
);

  logic [3:0] q_q;
  logic [3:0] q_d;
  logic [3:0] load_data;
  logic       count_en;

  assign load_data = {port6, port5, port4, port3};
  assign count_en  = port7 & port10;

  // Any X/Z on clear, load or the combined enable falls to the default arm,
  // so undriven board nets show up as an unknown count.
  always_comb begin
    q_d = q_q;
    case ({port1, port9, count_en})
      3'b100,
      3'b101:  q_d = load_data;
      3'b110:  q_d = q_q;
      3'b111:  q_d = q_q + 4'd1;
      default: q_d = 4'hx;
    endcase
  end

  always_ff @(posedge port2 or negedge port1) begin
    if (!port1) begin
      q_q <= 4'h0;
    end else begin
      q_q <= q_d;
    end
  end

  assign port11 = q_q[3];
  assign port12 = q_q[2];
  assign port13 = q_q[1];
  assign port14 = q_q[0];
  assign port15 = port10 & (q_q == 4'hF);

  // Zero-delay cycle model: timing parameters are kept for drop-in compatibility only.
  localparam int unsigned TpdSum = TPD_CLK_Q + TPD_CLR_Q + TPD_RCO;

  logic unused_pins;
  assign unused_pins = ^{port8, port16, (TpdSum == 0)};

endmodule

// File: tb/tb_ic74ls161.sv
// Directed bench for ic74ls161: vector table plus clear/cascade corner sequences.
module tb_ic74ls161;

  logic       clk;
  logic       clr_n;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic [3:0] dcba;
  logic       gnd;
  logic       vcc;

  logic       qa0, qb0, qc0, qd0, rco0;
  logic       qa1, qb1, qc1, qd1, rco1;
  logic [3:0] q0;
  logic [3:0] q1;

  int n_cmp;
  int n_bad;

  assign q0 = {qd0, qc0, qb0, qa0};
  assign q1 = {qd1, qc1, qb1, qa1};

  ic74ls161 u_lo (
    .port1 (clr_n),
    .port2 (clk),
    .port3 (dcba[0]),
    .port4 (dcba[1]),
    .port5 (dcba[2]),
    .port6 (dcba[3]),
    .port7 (enp),
    .port8 (gnd),
    .port9 (load_n),
    .port10(ent),
    .port11(qd0),
    .port12(qc0),
    .port13(qb0),
    .port14(qa0),
    .port15(rco0),
    .port16(vcc)
  );

  // Upper nibble of the cascade: ENT fed from the lower counter's RCO.
  ic74ls161 u_hi (
    .port1 (clr_n),
    .port2 (clk),
    .port3 (dcba[0]),
    .port4 (dcba[1]),
    .port5 (dcba[2]),
    .port6 (dcba[3]),
    .port7 (enp),
    .port8 (gnd),
    .port9 (load_n),
    .port10(rco0),
    .port11(qd1),
    .port12(qc1),
    .port13(qb1),
    .port14(qa1),
    .port15(rco1),
    .port16(vcc)
  );

  typedef struct {
    logic       clr_n;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [3:0] dcba;
    logic       clk_edge;
    logic [3:0] exp_q;
    logic       exp_rco;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    clk    = 1'b0;
    clr_n  = 1'b0;
    load_n = 1'b1;
    enp    = 1'b0;
    ent    = 1'b0;
    dcba   = 4'h0;
    gnd    = 1'b0;
    vcc    = 1'b1;

    //             clr  ld   enp  ent  dcba  edge exp_q rco  name
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "reset"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 1'b1, 4'h9, 1'b0, "load9"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "async_clr"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, "edge_in_clr"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1, 4'hA, 1'b0, "loadA"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'hA, 1'b0, "hold_enp0_1"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'hA, 1'b0, "hold_enp0_2"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'hA, 1'b0, "hold_enp0_3"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1, 4'hD, 1'b0, "loadD"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'hE, 1'b0, "countE"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1, "countF"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, "rco_ent0"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'hF, 1'b1, "rco_ent1"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, "wrap0"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 1'b1, "loadF"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1, "holdF_1"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1, "holdF_2"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, "holdF_ent0"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'h3, 1'b0, "load_wins"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h3, 1'b0, "hold_ent0"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'h4, 1'b0, "count4"});

    #3;
    foreach (vecs[i]) begin
      clr_n  = vecs[i].clr_n;
      load_n = vecs[i].load_n;
      enp    = vecs[i].enp;
      ent    = vecs[i].ent;
      dcba   = vecs[i].dcba;
      if (vecs[i].clk_edge) tick();
      else #2;
      check4({vecs[i].name, "_q"}, q0, vecs[i].exp_q);
      check1({vecs[i].name, "_rco"}, rco0, vecs[i].exp_rco);
    end

    // Clear pulsed across a load edge: clear must win.
    load_n = 1'b0;
    dcba   = 4'h3;
    enp    = 1'b1;
    ent    = 1'b1;
    #4 clr_n = 1'b0;
    #1 clk = 1'b1;
    #1 clr_n = 1'b1;
    #4 clk = 1'b0;
    check4("clr_wins_q", q0, 4'h0);

    // Release needs no clock; the next edge counts normally.
    load_n = 1'b1;
    tick();
    check4("post_release_count", q0, 4'h1);

    // Cascade: clear, then 20 edges gives 8'h14.
    clr_n = 1'b0;
    #2;
    check4("casc_clr_hi", q1, 4'h0);
    clr_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 15) begin
        check4("casc15_lo", q0, 4'hF);
        check4("casc15_hi", q1, 4'h0);
        check1("casc15_rco", rco0, 1'b1);
      end
      if (e == 16) begin
        check4("casc16_lo", q0, 4'h0);
        check4("casc16_hi", q1, 4'h1);
      end
    end
    check4("casc20_lo", q0, 4'h4);
    check4("casc20_hi", q1, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
